// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_pkg
// Brief    : Shared state encodings, opcodes and ALU class codes for the
//            multicycle controller and the downstream function decoder.
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam logic [5:0] c_OP_ORI  = 6'b001101;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_J    = 6'b000010;

    localparam logic [1:0] c_ALU_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_SUB   = 2'b01;
    localparam logic [1:0] c_ALU_RTYPE = 2'b10;
    localparam logic [1:0] c_ALU_ORI   = 2'b11;

    localparam logic [1:0] c_SRCB_B     = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_SHIFT = 2'b11;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Controller <-> datapath strobe bundle. master = controller.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic       Mem_Ready;
    logic [1:0] ALU_op;
    logic       ALU_SrcA;
    logic [1:0] ALU_SrcB;
    logic       Ext_Zero;
    logic       PC_Write;
    logic       PC_Write_Cond;
    logic       IorD;
    logic       Mem_Read;
    logic       Mem_Write;
    logic       IR_Write;
    logic       Mem_to_Reg;
    logic       Reg_Write;
    logic       Reg_Dst;
    logic [1:0] PC_Source;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  Opcode, Mem_Ready,
        output ALU_op, ALU_SrcA, ALU_SrcB, Ext_Zero, PC_Write, PC_Write_Cond,
               IorD, Mem_Read, Mem_Write, IR_Write, Mem_to_Reg, Reg_Write,
               Reg_Dst, PC_Source, Illegal, State
    );

    modport slave (
        output Opcode, Mem_Ready,
        input  ALU_op, ALU_SrcA, ALU_SrcB, Ext_Zero, PC_Write, PC_Write_Cond,
               IorD, Mem_Read, Mem_Write, IR_Write, Mem_to_Reg, Reg_Write,
               Reg_Dst, PC_Source, Illegal, State
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore FSM sequencing a multicycle MIPS-style datapath.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst,
    multicycle_control_if.master bus
);

    state_t r_state;
    state_t w_next_state;

    // State register; reset parks the FSM in FETCH.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next_state;
    end

    // Next-state selection; unused encodings fall back to FETCH.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:     w_next_state = bus.Mem_Ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Opcode)
                    c_OP_LW, c_OP_SW:    w_next_state = S_MEM_ADDR;
                    c_OP_R:              w_next_state = S_R_EXEC;
                    c_OP_BEQ:            w_next_state = S_BRANCH;
                    c_OP_J:              w_next_state = S_JUMP;
                    c_OP_ADDI, c_OP_ORI: w_next_state = S_I_EXEC;
                    default:             w_next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (bus.Opcode == c_OP_LW)      w_next_state = S_MEM_READ;
                else if (bus.Opcode == c_OP_SW) w_next_state = S_MEM_WRITE;
                else                            w_next_state = S_FETCH;
            end
            S_MEM_READ:  w_next_state = bus.Mem_Ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_next_state = S_FETCH;
            S_MEM_WRITE: w_next_state = bus.Mem_Ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    w_next_state = S_R_WB;
            S_R_WB:      w_next_state = S_FETCH;
            S_BRANCH:    w_next_state = S_FETCH;
            S_JUMP:      w_next_state = S_FETCH;
            S_I_EXEC:    w_next_state = S_I_WB;
            S_I_WB:      w_next_state = S_FETCH;
            default:     w_next_state = S_FETCH;
        endcase
    end

    // Output decode from the state register; everything is forced low in reset
    // so no write strobe can fire on a cycle where rst is sampled high.
    always_comb begin
        bus.ALU_op        = c_ALU_ADD;
        bus.ALU_SrcA      = 1'b0;
        bus.ALU_SrcB      = c_SRCB_B;
        bus.Ext_Zero      = 1'b0;
        bus.PC_Write      = 1'b0;
        bus.PC_Write_Cond = 1'b0;
        bus.IorD          = 1'b0;
        bus.Mem_Read      = 1'b0;
        bus.Mem_Write     = 1'b0;
        bus.IR_Write      = 1'b0;
        bus.Mem_to_Reg    = 1'b0;
        bus.Reg_Write     = 1'b0;
        bus.Reg_Dst       = 1'b0;
        bus.PC_Source     = c_PCSRC_ALU;
        bus.Illegal       = 1'b0;
        bus.State         = 4'd0;
        if (!rst) begin
            bus.State = r_state;
            case (r_state)
                S_FETCH: begin
                    bus.Mem_Read = 1'b1;
                    bus.ALU_SrcB = c_SRCB_FOUR;
                    bus.IR_Write = bus.Mem_Ready;
                    bus.PC_Write = bus.Mem_Ready;
                end
                S_DECODE: begin
                    bus.ALU_SrcB = c_SRCB_SHIFT;
                    case (bus.Opcode)
                        c_OP_R, c_OP_LW, c_OP_SW, c_OP_ADDI,
                        c_OP_ORI, c_OP_BEQ, c_OP_J: bus.Illegal = 1'b0;
                        default:                    bus.Illegal = 1'b1;
                    endcase
                end
                S_MEM_ADDR: begin
                    bus.ALU_SrcA = 1'b1;
                    bus.ALU_SrcB = c_SRCB_IMM;
                end
                S_MEM_READ: begin
                    bus.Mem_Read = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_MEM_WB: begin
                    bus.Reg_Write  = 1'b1;
                    bus.Mem_to_Reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    bus.IorD      = 1'b1;
                    bus.Mem_Write = 1'b1;
                end
                S_R_EXEC: begin
                    bus.ALU_SrcA = 1'b1;
                    bus.ALU_op   = c_ALU_RTYPE;
                end
                S_R_WB: begin
                    bus.Reg_Dst   = 1'b1;
                    bus.Reg_Write = 1'b1;
                end
                S_BRANCH: begin
                    bus.ALU_SrcA      = 1'b1;
                    bus.ALU_op        = c_ALU_SUB;
                    bus.PC_Write_Cond = 1'b1;
                    bus.PC_Source     = c_PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    bus.PC_Write  = 1'b1;
                    bus.PC_Source = c_PCSRC_JUMP;
                end
                S_I_EXEC: begin
                    bus.ALU_SrcA = 1'b1;
                    bus.ALU_SrcB = c_SRCB_IMM;
                    if (bus.Opcode == c_OP_ORI) begin
                        bus.ALU_op   = c_ALU_ORI;
                        bus.Ext_Zero = 1'b1;
                    end
                end
                S_I_WB: begin
                    bus.Reg_Write = 1'b1;
                end
                default: bus.State = r_state;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 Opcode  in  6  instruction opcode; stable from the cycle after the IR write.
REQ-005 Mem_Ready  in  1  memory handshake; the current access completes this cycle.
REQ-006 ALU_op  out  2  class code: 00 add, 01 branch compare (subtract), 10 R-type (decode funct), 11 ori.
REQ-007 ALU_SrcA  out  1  0 = PC, 1 = register A.
REQ-008 ALU_SrcB  out  2  00 = B, 01 = constant 4, 10 = sign/zero-extended immediate, 11 = shifted immediate.
REQ-009 Ext_Zero  out  1  1 = zero-extend the immediate (ori only).
REQ-010 PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, IR_Write, Mem_to_Reg, Reg_Write, Reg_Dst  out  1 each  standard multicycle datapath strobes.
REQ-011 PC_Source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
REQ-012 Illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-013 State  out  4  current state, for debug.

Function
REQ-014 The FSM SHALL be Moore. Outputs SHALL be decoded from the state register; the exceptions are Opcode-qualified ALU_op and Ext_Zero in I_EXEC, Illegal in DECODE, and Mem_Ready-qualified strobes.
REQ-015 Opcodes: R=000000, lw=100011, sw=101011, addi=001000, ori=001101, beq=000100, j=000010.
REQ-016 Any output not listed for a state SHALL be 0.
REQ-017 FETCH: Mem_Read=1, IorD=0, SrcA=0, SrcB=01, ALU_op=00, PC_Source=00.
  - IR_Write=PC_Write=Mem_Ready.
  - Stay in FETCH while Mem_Ready=0; go to DECODE when Mem_Ready=1.
REQ-018 DECODE: SrcA=0, SrcB=11, ALU_op=00.
  - Next state: lw/sw -> MEM_ADDR, R -> R_EXEC, beq -> BRANCH, j -> JUMP, addi/ori -> I_EXEC.
  - Any other opcode: Illegal=1, next state FETCH.
REQ-019 MEM_ADDR: SrcA=1, SrcB=10, ALU_op=00; lw -> MEM_READ, sw -> MEM_WRITE.
REQ-020 MEM_READ: Mem_Read=1, IorD=1; hold until Mem_Ready=1, then go to MEM_WB.
REQ-021 MEM_WB: Reg_Write=1, Mem_to_Reg=1, Reg_Dst=0; next state FETCH.
REQ-022 MEM_WRITE: IorD=1, Mem_Write=1 on every cycle of the state; hold until Mem_Ready=1, then go to FETCH.
REQ-023 R_EXEC: SrcA=1, SrcB=00, ALU_op=10; next state R_WB.
REQ-024 R_WB: Reg_Dst=1, Reg_Write=1, Mem_to_Reg=0; next state FETCH.
REQ-025 BRANCH: SrcA=1, SrcB=00, ALU_op=01, PC_Write_Cond=1, PC_Source=01; next state FETCH.
REQ-026 JUMP: PC_Write=1, PC_Source=10; next state FETCH.
REQ-027 I_EXEC: SrcA=1, SrcB=10; next state I_WB.
  - addi: ALU_op=00, Ext_Zero=0.
  - ori: ALU_op=11, Ext_Zero=1.
REQ-028 I_WB: Reg_Dst=0, Reg_Write=1, Mem_to_Reg=0; next state FETCH.
REQ-029 Instruction latency (Mem_Ready tied 1):
  - lw 5 cycles; sw, R, addi, ori 4 cycles; beq, j 3 cycles.
  - Each cycle of Mem_Ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
REQ-030 An unused state encoding SHALL transition to FETCH on the next edge with all strobes 0.

Reset
REQ-031 While rst=1, every output SHALL be 0; this includes ALU_op, PC_Source and State.
REQ-032 The state register SHALL load FETCH on the first edge after rst falls, and reset SHALL override every transition, including reset mid-wait in MEM_READ or MEM_WRITE.
REQ-033 No write strobe (PC_Write, PC_Write_Cond, IR_Write, Mem_Write, Reg_Write) SHALL be asserted on the cycle rst is sampled high.

Structure
REQ-034 A shared package SHALL hold the state encodings, the opcode constants and the ALU_op class constants, so the downstream function decoder uses identical values.
REQ-035 The block SHALL be a single module with no sub-modules; next-state logic and output decode SHALL be separate processes.

Verification
REQ-036 Reset: rst=1 for 2 cycles, then Opcode=100011 with Mem_Ready=1. State SHALL step 0,1,2,3,4,0 and Reg_Write=1 only in MEM_WB.
REQ-037 Wait states: sw with Mem_Ready=0 for 3 cycles in MEM_WRITE. Mem_Write SHALL stay 1 for 4 cycles and the instruction SHALL take 7 cycles.
REQ-038 ALU_op per class: R -> 10 in R_EXEC; ori -> 11 with Ext_Zero=1 in I_EXEC; addi -> 00; beq -> 01 with PC_Write_Cond=1.
REQ-039 Illegal opcode 111111: Illegal pulses 1 in DECODE, the next state is FETCH, and no write strobe asserts.
REQ-040 Reset mid-wait: rst=1 while in MEM_READ with Mem_Ready=0. All outputs SHALL be 0 the next cycle and the FSM SHALL restart at FETCH.
